// File: rtl/mem_wb_stage.sv
// Elastic MEM/WB pipeline register with valid/ready handshake and synchronous flush.
// Optional second (skid) entry enabled by defining MEM_WB_SKID_EN.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 2
) (
  input  logic              Clk_in,
  input  logic              Reset_n_in,
  input  logic              Flush_in,
  input  logic              In_valid_in,
  output logic              In_ready_out,
  input  logic [CTRL_W-1:0] Ctrl_in,
  input  logic [DATA_W-1:0] ALUResult_in,
  input  logic [DATA_W-1:0] MemData_in,
  input  logic [REG_W-1:0]  DestReg_in,
  output logic              Out_valid_out,
  input  logic              Out_ready_in,
  output logic [CTRL_W-1:0] Ctrl_out,
  output logic [DATA_W-1:0] ALUResult_out,
  output logic [DATA_W-1:0] MemData_out,
  output logic [REG_W-1:0]  DestReg_out,
  output logic [DATA_W-1:0] WBData_out,
  output logic [1:0]        Occupancy_out
);

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_alu;
  logic [DATA_W-1:0] main_mem;
  logic [REG_W-1:0]  main_dest;

  logic xfer_in;
  logic xfer_out;

  assign xfer_in  = In_valid_in && In_ready_out;
  assign xfer_out = main_valid && Out_ready_in;

`ifdef MEM_WB_SKID_EN
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_alu;
  logic [DATA_W-1:0] skid_mem;
  logic [REG_W-1:0]  skid_dest;

  // Ready depends only on registered state, breaking the combinational ready path.
  assign In_ready_out  = !skid_valid && !Flush_in;
  // The skid entry is only ever occupied while main is occupied.
  assign Occupancy_out = {skid_valid, main_valid && !skid_valid};

  always_ff @(posedge Clk_in or negedge Reset_n_in) begin
    if (!Reset_n_in) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_alu   <= '0;
      main_mem   <= '0;
      main_dest  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_alu   <= '0;
      skid_mem   <= '0;
      skid_dest  <= '0;
    end else if (Flush_in) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid) begin
      if (xfer_in) begin
        main_valid <= 1'b1;
        main_ctrl  <= Ctrl_in;
        main_alu   <= ALUResult_in;
        main_mem   <= MemData_in;
        main_dest  <= DestReg_in;
      end
    end else if (xfer_out) begin
      if (skid_valid) begin
        main_ctrl  <= skid_ctrl;
        main_alu   <= skid_alu;
        main_mem   <= skid_mem;
        main_dest  <= skid_dest;
        skid_valid <= 1'b0;
      end else if (xfer_in) begin
        main_ctrl <= Ctrl_in;
        main_alu  <= ALUResult_in;
        main_mem  <= MemData_in;
        main_dest <= DestReg_in;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (xfer_in) begin
      skid_valid <= 1'b1;
      skid_ctrl  <= Ctrl_in;
      skid_alu   <= ALUResult_in;
      skid_mem   <= MemData_in;
      skid_dest  <= DestReg_in;
    end
  end
`else
  assign In_ready_out  = !Flush_in && (!main_valid || Out_ready_in);
  assign Occupancy_out = {1'b0, main_valid};

  always_ff @(posedge Clk_in or negedge Reset_n_in) begin
    if (!Reset_n_in) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_alu   <= '0;
      main_mem   <= '0;
      main_dest  <= '0;
    end else if (Flush_in) begin
      main_valid <= 1'b0;
    end else if (xfer_in) begin
      main_valid <= 1'b1;
      main_ctrl  <= Ctrl_in;
      main_alu   <= ALUResult_in;
      main_mem   <= MemData_in;
      main_dest  <= DestReg_in;
    end else if (xfer_out) begin
      main_valid <= 1'b0;
    end
  end
`endif

  // RegWrite is gated so a bubble never writes the register file.
  assign Out_valid_out = main_valid;
  assign Ctrl_out      = {main_ctrl[CTRL_W-1:1], main_ctrl[0] && main_valid};
  assign ALUResult_out = main_alu;
  assign MemData_out   = main_mem;
  assign DestReg_out   = main_dest;
  assign WBData_out    = main_ctrl[1] ? main_mem : main_alu;

endmodule
